// File: rtl/lexer_pkg.sv
// Shared definitions for the keyword lexer slice.
// Holds the token codes, the word separator, the match-state encoding,
// the token record carried through the FIFO, and small character helpers.
package lexer_pkg;

  localparam logic [1:0] TOK_EOS   = 2'd0;
  localparam logic [1:0] TOK_BEGIN = 2'd1;
  localparam logic [1:0] TOK_END   = 2'd2;
  localparam logic [1:0] TOK_OTHER = 2'd3;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // One state per matched prefix of "begin" / "end", plus IDLE (no word open)
  // and OTH (word open but already known not to be a keyword).
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_B1   = 4'd1,
    ST_B2   = 4'd2,
    ST_B3   = 4'd3,
    ST_B4   = 4'd4,
    ST_B5   = 4'd5,
    ST_E1   = 4'd6,
    ST_E2   = 4'd7,
    ST_E3   = 4'd8,
    ST_OTH  = 4'd9
  } match_state_e;

  typedef struct packed {
    logic [1:0] code;
    logic       last;
  } token_t;

  // Map A-Z onto a-z; every other byte passes through untouched.
  function automatic logic [7:0] fold_case(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A) begin
      return c + 8'h20;
    end else begin
      return c;
    end
  endfunction

  // State after consuming one (already folded) word character.
  function automatic match_state_e next_match(input match_state_e s,
                                              input logic [7:0]   c);
    match_state_e n;
    n = ST_OTH;
    case (s)
      ST_IDLE: begin
        if (c == 8'h62)      n = ST_B1;
        else if (c == 8'h65) n = ST_E1;
        else                 n = ST_OTH;
      end
      ST_B1:   n = (c == 8'h65) ? ST_B2 : ST_OTH;
      ST_B2:   n = (c == 8'h67) ? ST_B3 : ST_OTH;
      ST_B3:   n = (c == 8'h69) ? ST_B4 : ST_OTH;
      ST_B4:   n = (c == 8'h6E) ? ST_B5 : ST_OTH;
      ST_E1:   n = (c == 8'h6E) ? ST_E2 : ST_OTH;
      ST_E2:   n = (c == 8'h64) ? ST_E3 : ST_OTH;
      // B5, E3 and OTH: any further character disqualifies the keyword
      default: n = ST_OTH;
    endcase
    return n;
  endfunction

  // Token code for a word that closes while the FSM sits in state s.
  function automatic logic [1:0] word_code(input match_state_e s);
    case (s)
      ST_B5:   return TOK_BEGIN;
      ST_E3:   return TOK_END;
      default: return TOK_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/token_fifo.sv
// Synchronous token FIFO.
// Ports:
//   clk, reset       clock / asynchronous active-high reset (empties the FIFO)
//   i_push, i_data   write strobe and token; ignored while full
//   i_pop            read strobe; ignored while empty
//   o_data           head token (from storage, stable until popped)
//   o_full, o_empty  occupancy flags derived from the registered count
//   o_count          number of stored tokens, 0..DEPTH
module token_fifo
  import lexer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  token_t                 i_data,
  input  logic                   i_pop,
  output token_t                 o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  token_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage and pointers; pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/keyword_lexer.sv
// Keyword lexer: folds case, splits the character stream on spaces and
// classifies each word as BEGIN, END or OTHER, queuing tokens in a FIFO.
// Ports:
//   clk, reset                 clock / asynchronous active-high reset
//   in_valid/in_ready          character handshake (in_char, in_last)
//   tok_valid/tok_ready        token handshake (tok_code, tok_last)
//   tok_count                  tokens popped since reset, saturating
module keyword_lexer
  import lexer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic             in_last,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [1:0]       tok_code,
  output logic             tok_last,
  output logic [CNT_W-1:0] tok_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  match_state_e     r_state;
  logic [CNT_W-1:0] r_tok_count;

  logic [7:0]       w_fold;
  logic             w_is_space;
  logic             w_accept;
  match_state_e     w_word_state;
  logic             w_push;
  token_t           w_tok;
  logic             w_pop;
  token_t           w_head;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;

  assign w_fold       = fold_case(in_char);
  assign w_is_space   = (w_fold == CHAR_SPACE);
  assign in_ready     = !w_full;
  assign w_accept     = in_valid && in_ready;
  assign w_word_state = next_match(r_state, w_fold);
  assign tok_valid    = (w_count != '0);
  assign w_pop        = tok_ready && !w_empty;
  assign tok_code     = w_head.code;
  assign tok_last     = w_head.last;
  assign tok_count    = r_tok_count;

  // Token generation: at most one push per accepted character.
  // On in_last the character is consumed first, so a final word character
  // is classified with the state it leads to; a final space closes the
  // open word, or yields EOS when none is open.
  always_comb begin
    w_push = 1'b0;
    w_tok  = '0;
    if (w_accept) begin
      if (w_is_space) begin
        if (r_state != ST_IDLE) begin
          w_push      = 1'b1;
          w_tok.code  = word_code(r_state);
          w_tok.last  = in_last;
        end else if (in_last) begin
          w_push      = 1'b1;
          w_tok.code  = TOK_EOS;
          w_tok.last  = 1'b1;
        end else begin
          w_push      = 1'b0;
        end
      end else if (in_last) begin
        w_push      = 1'b1;
        w_tok.code  = word_code(w_word_state);
        w_tok.last  = 1'b1;
      end else begin
        w_push      = 1'b0;
      end
    end else begin
      w_push = 1'b0;
    end
  end

  // Match FSM: closes the word on a space or end of stream, else advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else if (w_accept) begin
      if (w_is_space || in_last) begin
        r_state <= ST_IDLE;
      end else begin
        r_state <= w_word_state;
      end
    end else begin
      r_state <= r_state;
    end
  end

  // Popped-token statistic, held at all-ones once reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tok_count <= '0;
    end else if (w_pop && (r_tok_count != '1)) begin
      r_tok_count <= r_tok_count + CNT_W'(1);
    end else begin
      r_tok_count <= r_tok_count;
    end
  end

  token_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_tok),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_keyword_lexer.sv
// Bench for keyword_lexer. A second instance with a 2-bit counter shares
// all inputs so that counter saturation is reachable in a short run.
module tb_keyword_lexer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        in_last = 1'b0;
  logic        tok_ready = 1'b0;
  logic        in_ready, tok_valid, tok_last;
  logic [1:0]  tok_code;
  logic [15:0] tok_count;
  logic        in_ready_s, tok_valid_s, tok_last_s;
  logic [1:0]  tok_code_s;
  logic [1:0]  tok_count_s;

  int    n_checks = 0;
  int    n_err = 0;
  bit    rnd_ready = 1'b0;

  // Reference model state: queued tokens encoded code*2+last, popped log.
  int    exp_q[$];
  int    log_q[$];
  int    pops = 0;
  string cur_word = "";

  keyword_lexer #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_last(in_last), .tok_valid(tok_valid),
    .tok_ready(tok_ready), .tok_code(tok_code), .tok_last(tok_last),
    .tok_count(tok_count));

  keyword_lexer #(.FIFO_DEPTH(DEPTH), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_char(in_char), .in_last(in_last), .tok_valid(tok_valid_s),
    .tok_ready(tok_ready), .tok_code(tok_code_s), .tok_last(tok_last_s),
    .tok_count(tok_count_s));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int classify(input string w);
    if (w == "begin") return 1;
    if (w == "end")   return 2;
    return 3;
  endfunction

  // Word-level model: collect folded characters, classify on close.
  task automatic model_char(input logic [7:0] c_in, input logic last);
    logic [7:0] c;
    c = c_in;
    if (c >= 8'h41 && c <= 8'h5A) c = c + 8'h20;
    if (c != 8'h20) cur_word = $sformatf("%s%c", cur_word, c);
    if (c == 8'h20 || last) begin
      if (cur_word.len() > 0) exp_q.push_back(classify(cur_word) * 2 + (last ? 1 : 0));
      else if (last)          exp_q.push_back(1);
      cur_word = "";
    end
  endtask

  // Cycle monitor: model FIFO content must equal the DUT FIFO every cycle.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      pops = 0;
      cur_word = "";
    end else begin
      check("tok_valid", {31'd0, tok_valid}, {31'd0, exp_q.size() != 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < DEPTH});
      check("tok_valid_s", {31'd0, tok_valid_s}, {31'd0, exp_q.size() != 0});
      check("in_ready_s", {31'd0, in_ready_s}, {31'd0, exp_q.size() < DEPTH});
      check("tok_count", {16'd0, tok_count}, (pops > 65535) ? 65535 : pops);
      check("tok_count_sat", {30'd0, tok_count_s}, (pops > 3) ? 3 : pops);
      if (exp_q.size() != 0) begin
        check("tok_head", {29'd0, tok_code, tok_last}, exp_q[0]);
        check("tok_head_s", {29'd0, tok_code_s, tok_last_s}, exp_q[0]);
        if (tok_ready) begin
          log_q.push_back({29'd0, tok_code, tok_last});
          void'(exp_q.pop_front());
          pops++;
        end
      end
      if (in_valid && in_ready) model_char(in_char, in_last);
    end
  end

  task automatic send(input logic [7:0] c, input bit last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready || n >= 200) break;
      @(posedge clk); #2;
      if (rnd_ready) tok_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (rnd_ready) tok_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) send(s[i], last && (i == s.len() - 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    tok_ready = 1'b1;
    while ((tok_valid || exp_q.size() != 0) && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
    check("drain_valid", {31'd0, tok_valid}, 32'd0);
  endtask

  task automatic check_log(input string tag, input int start, input int e[$]);
    check({tag, "_ntok"}, log_q.size() - start, e.size());
    for (int i = 0; i < e.size(); i++) begin
      if (start + i < log_q.size()) check({tag, "_tok"}, log_q[start + i], e[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int e[$];
    string alpha;
    string s;

    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_tok_valid", {31'd0, tok_valid}, 32'd0);
    check("rst_tok_code", {30'd0, tok_code}, 32'd0);
    check("rst_tok_last", {31'd0, tok_last}, 32'd0);
    check("rst_tok_count", {16'd0, tok_count}, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // 1: mixed case keywords, last on a word char
    tok_ready = 1'b1;
    st = log_q.size();
    send_str("BeGiN EnD x", 1'b1);
    drain();
    e = '{2, 4, 7};
    check_log("t1", st, e);
    check("t1_count", {16'd0, tok_count}, 32'd3);

    // 2: over-long keyword, double space, prefix words
    st = log_q.size();
    send_str("beginx  en e", 1'b1);
    drain();
    e = '{6, 6, 7};
    check_log("t2", st, e);

    // 3: backpressure fills the FIFO, fifth word stalls
    tok_ready = 1'b0;
    st = log_q.size();
    send_str("end end end end ", 1'b0);
    check("t3_full_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_char  = 8'h65;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_stall_ready", {31'd0, in_ready}, 32'd0);
    check("t3_stall_valid", {31'd0, tok_valid}, 32'd1);
    @(posedge clk); #2;
    tok_ready = 1'b1;
    send_str("end ", 1'b0);
    drain();
    e = '{4, 4, 4, 4, 4};
    check_log("t3", st, e);
    check("t3_ready_back", {31'd0, in_ready}, 32'd1);
    check("t3_count", {16'd0, tok_count}, 32'd11);

    // 4: last on space, lone space, lone word char; one-cycle latency
    tok_ready = 1'b0;
    st = log_q.size();
    send_str("end ", 1'b1);
    check("t4_latency", {31'd0, tok_valid}, 32'd1);
    repeat (2) @(negedge clk);
    check("t4_hold_code", {30'd0, tok_code}, 32'd2);
    check("t4_hold_last", {31'd0, tok_last}, 32'd1);
    drain();
    send_str(" ", 1'b1);
    drain();
    send_str("x", 1'b1);
    drain();
    e = '{5, 1, 7};
    check_log("t4", st, e);

    // 5: reset mid-word with tokens queued
    tok_ready = 1'b0;
    send_str("end x ", 1'b0);
    send_str("beg", 1'b0);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    check("t5_valid", {31'd0, tok_valid}, 32'd0);
    check("t5_count", {16'd0, tok_count}, 32'd0);
    check("t5_ready", {31'd0, in_ready}, 32'd1);
    st = log_q.size();
    tok_ready = 1'b1;
    send_str("in ", 1'b0);
    drain();
    e = '{6};
    check_log("t5", st, e);
    check("t5_count_after", {16'd0, tok_count}, 32'd1);

    // 6: saturation of the narrow counter (all-ones = 3)
    send_str("a b c d ", 1'b0);
    drain();
    check("t6_sat", {30'd0, tok_count_s}, 32'd3);
    check("t6_count", {16'd0, tok_count}, 32'd5);
    send_str("end ", 1'b0);
    drain();
    check("t6_sat_hold", {30'd0, tok_count_s}, 32'd3);

    // Random streams with random backpressure
    alpha = "bBeEgGiInNdDx\t.   ";
    rnd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int len;
      len = $urandom_range(1, 16);
      s = "";
      for (int j = 0; j < len; j++) s = {s, alpha.substr(0, 0)};
      for (int j = 0; j < len; j++) s[j] = alpha[$urandom_range(0, alpha.len() - 1)];
      send_str(s, 1'b1);
    end
    rnd_ready = 1'b0;
    drain();
    check("rnd_count", {16'd0, tok_count}, pops);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
